// File: rtl/main_dot_mac.sv
// Pipelined fixed-point dot-product MAC: one DATA_N-wide beat per channel, HID_LENGTH channels per frame.
// Define MAIN_DOT_SAT_EN to saturate each channel result; otherwise the result wraps to BIT_LENGTH bits.
module main_dot_mac #(
  parameter int DATA_N     = 6,
  parameter int BIT_LENGTH = 16,
  parameter int HID_LENGTH = 8,
  parameter int FRAC_BITS  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           run,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_N*BIT_LENGTH-1:0]   data_in,
  input  logic [DATA_N*BIT_LENGTH-1:0]   weight_in,
  output logic                           valid,
  output logic                           busy,
  output logic [HID_LENGTH*BIT_LENGTH-1:0] data_out
);

  localparam int PROD_W = 2 * BIT_LENGTH;
  localparam int SUM_W  = PROD_W + $clog2(DATA_N);
  localparam int CNT_W  = (HID_LENGTH > 1) ? $clog2(HID_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         beat_cnt;
  logic                     accept;
  logic                     last_beat;

  logic signed [PROD_W-1:0] prod_c [DATA_N];
  logic signed [PROD_W-1:0] s1_prod [DATA_N];
  logic                     s1_valid;
  logic [CNT_W-1:0]         s1_idx;

  logic signed [SUM_W-1:0]  sum_c;
  logic signed [SUM_W-1:0]  s2_sum;
  logic                     s2_valid;
  logic [CNT_W-1:0]         s2_idx;

  logic signed [SUM_W-1:0]  shifted;
  logic [BIT_LENGTH-1:0]    res;
  logic [BIT_LENGTH-1:0]    slots      [HID_LENGTH];
  logic [BIT_LENGTH-1:0]    slots_next [HID_LENGTH];
  logic [HID_LENGTH*BIT_LENGTH-1:0] slots_flat;

  assign accept    = in_valid & in_ready;
  assign last_beat = (beat_cnt == CNT_W'(HID_LENGTH - 1));

  always_comb begin
    for (int i = 0; i < DATA_N; i++) begin
      prod_c[i] = PROD_W'($signed(data_in[i*BIT_LENGTH +: BIT_LENGTH]))
                * PROD_W'($signed(weight_in[i*BIT_LENGTH +: BIT_LENGTH]));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      for (int i = 0; i < DATA_N; i++) s1_prod[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx <= beat_cnt;
        for (int i = 0; i < DATA_N; i++) s1_prod[i] <= prod_c[i];
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < DATA_N; i++) sum_c = sum_c + SUM_W'(s1_prod[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_sum   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_idx <= s1_idx;
        s2_sum <= sum_c;
      end
    end
  end

  assign shifted = s2_sum >>> FRAC_BITS;

`ifdef MAIN_DOT_SAT_EN
  localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-BIT_LENGTH+1){1'b0}}, {(BIT_LENGTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-BIT_LENGTH+1){1'b1}}, {(BIT_LENGTH-1){1'b0}}};

  always_comb begin
    res = shifted[BIT_LENGTH-1:0];
    if (shifted > MAX_V)      res = MAX_V[BIT_LENGTH-1:0];
    else if (shifted < MIN_V) res = MIN_V[BIT_LENGTH-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^shifted[SUM_W-1:BIT_LENGTH];
  assign res       = shifted[BIT_LENGTH-1:0];
`endif

  // Stage 3 write is merged here so the DONE shadow load sees the final beat on the same edge.
  always_comb begin
    slots_next = slots;
    if (s2_valid) slots_next[s2_idx] = res;
    slots_flat = '0;
    for (int k = 0; k < HID_LENGTH; k++) slots_flat[k*BIT_LENGTH +: BIT_LENGTH] = slots_next[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < HID_LENGTH; k++) slots[k] <= '0;
    end else begin
      slots <= slots_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state    <= LOAD;
            beat_cnt <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Stage 1 empty means only the final stage-2 entry remains, and it retires this edge.
          if (!s1_valid) begin
            state    <= DONE;
            valid    <= 1'b1;
            data_out <= slots_flat;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_dot_mac.sv
// Scoreboard bench for main_dot_mac: two instances (FRAC_BITS 0 and 8) share stimulus,
// each with its own expected-frame queue popped by a monitor on every valid pulse.
module tb_main_dot_mac;

  localparam int DN = 6;
  localparam int BL = 16;
  localparam int HL = 8;

  logic clk = 1'b0;
  logic rst, run, in_valid;
  logic [DN*BL-1:0] data_in, weight_in;

  logic in_ready0, valid0, busy0;
  logic [HL*BL-1:0] data_out0;
  logic in_ready8, valid8, busy8;
  logic [HL*BL-1:0] data_out8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept_cyc = 0;

  logic [DN*BL-1:0] fd [4][HL];
  logic [DN*BL-1:0] fw [4][HL];
  logic [HL*BL-1:0] e0 [4];
  logic [HL*BL-1:0] e8 [4];
  logic [HL*BL-1:0] q0 [$];
  logic [HL*BL-1:0] q8 [$];

  main_dot_mac #(.DATA_N(DN), .BIT_LENGTH(BL), .HID_LENGTH(HL), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_ready(in_ready0),
    .data_in(data_in), .weight_in(weight_in), .valid(valid0), .busy(busy0), .data_out(data_out0)
  );

  main_dot_mac #(.DATA_N(DN), .BIT_LENGTH(BL), .HID_LENGTH(HL), .FRAC_BITS(8)) dut8 (
    .clk(clk), .rst(rst), .run(run), .in_valid(in_valid), .in_ready(in_ready8),
    .data_in(data_in), .weight_in(weight_in), .valid(valid8), .busy(busy8), .data_out(data_out8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [HL*BL-1:0] act, input logic [HL*BL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DN*BL-1:0] pack6(input int a0, a1, a2, a3, a4, a5);
    return {16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic init_frames();
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < HL; k++) begin
        fd[f][k] = '0;
        fw[f][k] = '0;
      end
    // Frame 0: 3*2+5*5+1*9+5*2+8*3+9*5 = 119, 5*2+6*2+1*4+2*5+3*1+4*2 = 47
    fd[0][0] = pack6(3, 5, 1, 5, 8, 9);
    fw[0][0] = pack6(2, 5, 9, 2, 3, 5);
    fd[0][1] = pack6(5, 6, 1, 2, 3, 4);
    fw[0][1] = pack6(2, 2, 4, 5, 1, 2);
    e0[0] = 128'h002F_0077;
    e8[0] = '0;
    for (int k = 0; k < HL; k++) begin
      fd[1][k] = pack6(-1, -1, -1, -1, -1, -1);
      fw[1][k] = pack6(1, 1, 1, 1, 1, 1);
      fd[2][k] = pack6(32767, 32767, 32767, 32767, 32767, 32767);
      fw[2][k] = pack6(32767, 32767, 32767, 32767, 32767, 32767);
      fd[3][k] = pack6(16'h0180, 0, 0, 0, 0, 0);
      fw[3][k] = pack6(16'h0200, 0, 0, 0, 0, 0);
    end
    // -6 exactly; with 8 fractional bits floor(-6/256) = -1
    e0[1] = {HL{16'hFFFA}};
    e8[1] = {HL{16'hFFFF}};
    // 6*0x3FFF0001 = 0x17FFA0006; >>>8 = 0x17FFA00
    // 0x180*0x200 = 0x30000; >>>8 = 0x300
`ifdef MAIN_DOT_SAT_EN
    e0[2] = {HL{16'h7FFF}};
    e8[2] = {HL{16'h7FFF}};
    e0[3] = {HL{16'h7FFF}};
`else
    e0[2] = {HL{16'h0006}};
    e8[2] = {HL{16'hFA00}};
    e0[3] = {HL{16'h0000}};
`endif
    e8[3] = {HL{16'h0300}};
  endtask

  task automatic applyStimulus(input int f, input int gap, input bit poke_run, input int n_beats);
    int waited;
    if (n_beats == HL) begin
      q0.push_back(e0[f]);
      q8.push_back(e8[f]);
    end
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < n_beats; k++) begin
      for (int g = 0; g < ((k == 0) ? 0 : gap); g++) begin
        in_valid  = 1'b0;
        run       = poke_run;
        data_in   = '1;
        weight_in = '1;
        @(negedge clk);
      end
      run       = 1'b0;
      in_valid  = 1'b1;
      data_in   = fd[f][k];
      weight_in = fw[f][k];
      waited = 0;
      while (!in_ready0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (waited >= 20) begin
        checks++;
        errors++;
        $display("[TB] FAIL in_ready_wait: actual=0 required=1 (frame %0d beat %0d)", f, k);
        in_valid = 1'b0;
        return;
      end
      last_accept_cyc = cyc + 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int f);
    int waited = 0;
    while (busy0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_wait: actual=busy required=idle (frame %0d)", f);
    end
    repeat (3) @(negedge clk);
    checkOutput("hold_dout0", data_out0, e0[f]);
    checkOutput("hold_dout8", data_out8, e8[f]);
  endtask

  // Monitor: every valid pulse must match the oldest queued frame; a pulse with nothing queued is an error.
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid0: actual=1 required=0");
      end else begin
        checkOutput("frame_dout0", data_out0, q0.pop_front());
        // valid occupies the cycle ending at edge accept+3, so it is seen at the negedge after accept+2
        checkOutput("latency", 128'(cyc - last_accept_cyc), 128'(2));
      end
    end
    if (valid8 === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid8: actual=1 required=0");
      end else begin
        checkOutput("frame_dout8", data_out8, q8.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    run       = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    weight_in = '0;
    init_frames();
    repeat (3) @(negedge clk);
    checkOutput("reset_dout", data_out0, '0);
    checkOutput("reset_valid", 128'(valid0), '0);
    checkOutput("reset_ready", 128'(in_ready0), '0);
    checkOutput("reset_busy", 128'(busy0), '0);
    rst = 1'b0;

    in_valid = 1'b1;
    data_in  = '1;
    repeat (3) @(negedge clk);
    checkOutput("idle_ready", 128'(in_ready0), '0);
    checkOutput("idle_busy", 128'(busy0), '0);
    in_valid = 1'b0;

    applyStimulus(0, 0, 1'b0, HL);
    wait_idle(0);
    applyStimulus(0, 2, 1'b1, HL);
    wait_idle(0);
    applyStimulus(1, 0, 1'b0, HL);
    wait_idle(1);
    applyStimulus(2, 1, 1'b0, HL);
    wait_idle(2);
    applyStimulus(3, 0, 1'b0, HL);
    wait_idle(3);

    applyStimulus(0, 0, 1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_dout0", data_out0, '0);
    checkOutput("midrst_dout8", data_out8, '0);
    checkOutput("midrst_busy", 128'(busy0), '0);
    checkOutput("midrst_ready", 128'(in_ready0), '0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_busy", 128'(busy0), '0);
    checkOutput("post_rst_dout", data_out0, '0);

    applyStimulus(0, 1, 1'b1, HL);
    wait_idle(0);

    checkOutput("queue_drained", 128'(q0.size() + q8.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/main_dot_mac.md
MAIN_DOT_MAC -- requirements
Module: main_dot_mac

Interface
REQ-001 Parameter DATA_N, default 6: number of signed elements per input beat.
REQ-002 Parameter BIT_LENGTH, default 16: width of each element and of each result, two's complement.
REQ-003 Parameter HID_LENGTH, default 8: number of beats per frame and number of output channels.
REQ-004 Parameter FRAC_BITS, default 8: fractional bits of the fixed-point format, range 0..BIT_LENGTH-1.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 run  input  1  frame start request; sampled only in IDLE.
REQ-008 in_valid  input  1  current data_in/weight_in beat is valid.
REQ-009 in_ready  output  1  block accepts a beat this cycle.
REQ-010 data_in  input  DATA_N*BIT_LENGTH  element i at bits [i*BIT_LENGTH +: BIT_LENGTH].
REQ-011 weight_in  input  DATA_N*BIT_LENGTH  same packing as data_in.
REQ-012 valid  output  1  one-cycle pulse: data_out holds a completed frame.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 data_out  output  HID_LENGTH*BIT_LENGTH  channel k at bits [k*BIT_LENGTH +: BIT_LENGTH].

Function
REQ-015 FSM states IDLE, LOAD, DRAIN, DONE; IDLE->LOAD on run; LOAD->DRAIN when beat HID_LENGTH-1 is accepted; DRAIN->DONE when the pipeline is empty; DONE->IDLE unconditionally after one cycle.
REQ-016 in_ready = 1 only in LOAD; a beat is accepted when in_valid & in_ready.
REQ-017 in_valid gaps in LOAD are allowed; the beat counter advances only on acceptance.
REQ-018 in_valid outside LOAD is ignored; run outside IDLE is ignored.
REQ-019 Stage 1 registers DATA_N signed products, each 2*BIT_LENGTH bits, full precision.
REQ-020 Stage 2 registers the signed sum of the products at 2*BIT_LENGTH+clog2(DATA_N) bits, lossless.
REQ-021 Stage 3 arithmetically shifts the sum right by FRAC_BITS (floor, no rounding), reduces it to BIT_LENGTH per REQ-029/030, and writes it to result slot k, where k is the beat's acceptance index.
REQ-022 Beat k always lands in channel k, independent of in_valid gaps.
REQ-023 Latency: last beat accepted at edge t -> valid high in cycle t+3 (DRAIN two cycles, DONE one cycle).
REQ-024 valid is high only in DONE, exactly one cycle per frame.
REQ-025 data_out is a shadow register loaded from the result slots on entry to DONE; it holds between frames and never shows a partial frame.
REQ-026 run held high continuously starts a new frame on the cycle after DONE (IDLE for one cycle, then LOAD).

Reset
REQ-027 rst has priority over all other inputs: state->IDLE, beat counter->0, pipeline valid bits->0, result slots->0.
REQ-028 Reset values: data_out=0, valid=0, in_ready=0, busy=0; rst mid-frame discards the frame and produces no valid pulse.

Configuration
REQ-029 With macro MAIN_DOT_SAT_EN defined, stage-3 reduction saturates to [-2^(BIT_LENGTH-1), 2^(BIT_LENGTH-1)-1].
REQ-030 Without MAIN_DOT_SAT_EN, stage-3 reduction keeps the low BIT_LENGTH bits (wrap-around); no other behaviour differs.

Verification
REQ-031 Use FRAC_BITS=0. Beat0 data {3,5,1,5,8,9}, weight {2,5,9,2,3,5}; beat1 data {5,6,1,2,3,4}, weight {2,2,4,5,1,2}; beats 2-7 zero -> ch0=119, ch1=47, ch2..7=0; valid exactly 3 cycles after the last accept.
REQ-032 Same frame with in_valid low for 2 cycles between every pair of beats -> identical data_out; single valid pulse.
REQ-033 Signed check: all data=-1 (0xFFFF), all weight=1 -> each channel 0xFFFA (-6), in both builds.
REQ-034 Overflow: all data and weight = 0x7FFF, FRAC_BITS=0 -> 0x7FFF with MAIN_DOT_SAT_EN; 0x0006 without.
REQ-035 FRAC_BITS=8: data 0x0180 (1.5), weight 0x0200 (2.0), element 0 only -> 0x0300 (3.0).
REQ-036 Reset mid-frame: assert rst after 4 accepted beats -> no valid pulse, data_out=0, busy=0; the next full frame completes correctly; run pulses during LOAD are ignored.
